// File: rtl/key_input_fifo.sv
// key_input_fifo: captures the slide-switch word on each key press (falling
// edge of the active-low key) into a small first-word-fall-through FIFO.
//
// Ports:
//   clk      - single clock, all state updates on rising edge
//   reset    - asynchronous active-high reset
//   key_n    - debounced, synchronised pushbutton, active-low
//   sw       - switch word captured on a press
//   rd_req   - consumer pop request (ignored while empty)
//   rd_data  - head entry, valid while rd_valid is high
//   rd_valid - FIFO holds at least one entry
//   full     - count == DEPTH
//   count    - number of stored entries
//   overflow - sticky: a press was dropped because the FIFO was full
//   clr_ovf  - synchronous clear for overflow (a same-cycle drop wins)
module key_input_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       key_n,
  input  logic [WIDTH-1:0]           sw,
  input  logic                       rd_req,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             prev;

  logic press;
  logic pop;
  logic push;
  logic ovf_event;

  // Falling edge of key_n; prev resets to 1 so a key held through reset
  // release still yields exactly one press.
  assign press = prev & ~key_n;

  // A pop frees a slot in the same cycle, so a press into a full FIFO
  // is accepted when it coincides with a pop.
  assign pop       = rd_req & rd_valid;
  assign push      = press & (~full | pop);
  assign ovf_event = press & full & ~pop;

  assign rd_valid = (count != CW'(0));
  assign full     = (count == CW'(DEPTH));
  assign rd_data  = mem[rd_ptr];

  // Key edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 1'b1;
    end else begin
      prev <= key_n;
    end
  end

  // Storage array; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sw;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Explicit occupancy counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as clr_ovf keeps it set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_event) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_input_fifo.sv
// tb_key_input_fifo: scoreboard bench for key_input_fifo. Accepted presses
// push the captured switch value onto a queue; pops compare the DUT head
// against the queue front.
module tb_key_input_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             key_n;
  logic [WIDTH-1:0] sw;
  logic             rd_req;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             clr_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] sb[$];
  logic             ovf_m;

  key_input_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .key_n    (key_n),
    .sw       (sw),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"},    32'(count),    32'(sb.size()));
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(sb.size() != 0));
    check({tag, ".full"},     32'(full),     32'(sb.size() == DEPTH));
    check({tag, ".overflow"}, 32'(overflow), 32'(ovf_m));
    if (sb.size() != 0) begin
      check({tag, ".rd_data"}, 32'(rd_data), 32'(sb[0]));
    end
  endtask

  // Model a press with no coinciding pop
  task automatic model_press();
    if (sb.size() < DEPTH) sb.push_back(sw);
    else                   ovf_m = 1'b1;
  endtask

  task automatic press(input logic [WIDTH-1:0] val, input string tag);
    sw    = val;
    key_n = 1'b0;
    model_press();
    step();
    check_state(tag);
    key_n = 1'b1;
    step();
  endtask

  task automatic pop_one(input string tag);
    check({tag, ".pre_valid"}, 32'(rd_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      check({tag, ".pre_data"}, 32'(rd_data), 32'(sb[0]));
      void'(sb.pop_front());
    end
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    check_state(tag);
  endtask

  initial begin
    reset   = 1'b1;
    key_n   = 1'b1;
    sw      = '0;
    rd_req  = 1'b0;
    clr_ovf = 1'b0;
    ovf_m   = 1'b0;
    #12;
    check_state("reset");
    step();
    reset = 1'b0;
    step();
    check_state("idle");

    // Single press held 10 cycles: exactly one entry
    sw    = 8'h5A;
    key_n = 1'b0;
    model_press();
    for (int i = 0; i < 10; i++) begin
      step();
      check_state("hold");
    end
    key_n = 1'b1;
    step();
    pop_one("hold_pop");

    // Fill and overflow
    for (int i = 1; i <= 5; i++) press(WIDTH'(i), "fill");
    check_state("filled");
    for (int i = 0; i < 4; i++) pop_one("drain");
    check_state("drained");

    // Clear overflow
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    ovf_m   = 1'b0;
    check_state("clr_ovf");

    // Full push+pop: both take effect, no overflow
    for (int i = 1; i <= 4; i++) press(WIDTH'(i), "refill");
    check({"fullpp", ".pre_data"}, 32'(rd_data), 32'(sb[0]));
    sw     = 8'd9;
    key_n  = 1'b0;
    rd_req = 1'b1;
    void'(sb.pop_front());
    sb.push_back(sw);
    step();
    rd_req = 1'b0;
    key_n  = 1'b1;
    check_state("fullpp");
    step();
    for (int i = 0; i < 4; i++) pop_one("fullpp_pop");

    // Wrap-around
    for (int i = 0; i < 10; i++) begin
      press(WIDTH'(i), "wrap_push");
      pop_one("wrap_pop");
    end

    // Pop while empty is ignored
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    check_state("empty_pop");

    // clr_ovf coincident with an overflow event: set wins
    for (int i = 0; i < 4; i++) press(WIDTH'(8'hA0 + i), "prefill");
    sw      = 8'hEE;
    key_n   = 1'b0;
    clr_ovf = 1'b1;
    model_press();
    step();
    key_n   = 1'b1;
    clr_ovf = 1'b0;
    check_state("clr_vs_set");
    step();
    pop_one("to_three");

    // Async reset mid-cycle with count 3
    #3;
    reset = 1'b1;
    #1;
    sb.delete();
    ovf_m = 1'b0;
    check_state("async_reset");

    // Key held low through reset release: one press
    sw    = 8'h77;
    key_n = 1'b0;
    step();
    step();
    check_state("in_reset");
    reset = 1'b0;
    sb.push_back(sw);
    step();
    check_state("post_release");
    for (int i = 0; i < 3; i++) begin
      step();
      check_state("post_hold");
    end
    key_n = 1'b1;
    step();
    pop_one("post_pop");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
